// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - issue front-end for the iterative divider: launch, select result, hold for writeback
module div_issue_ctrl #(
    parameter int WORD_WIDTH = 32,
    parameter int TAG_W      = 6,
    parameter int RD_W       = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_opcode,
    input  logic [WORD_WIDTH-1:0] in_src1,
    input  logic [WORD_WIDTH-1:0] in_src2,
    input  logic [TAG_W-1:0]      in_tag,
    input  logic [RD_W-1:0]       in_rd,
    input  logic                  flush,
    output logic                  div_start,
    output logic [2:0]            div_opcode,
    output logic [WORD_WIDTH-1:0] div_divident,
    output logic [WORD_WIDTH-1:0] div_divisor,
    input  logic [WORD_WIDTH-1:0] div_quotient,
    input  logic [WORD_WIDTH-1:0] div_remainder,
    input  logic                  div_finish,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [WORD_WIDTH-1:0] wb_data,
    output logic [TAG_W-1:0]      wb_tag,
    output logic [RD_W-1:0]       wb_rd,
    output logic                  busy
);
    localparam logic [2:0] DIV_OP_DIV  = 3'b100;
    localparam logic [2:0] DIV_OP_DIVU = 3'b101;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_next;
    logic              kill, kill_next;
    logic              sel_rem;
    logic [TAG_W-1:0]  op_tag;
    logic [RD_W-1:0]   op_rd;
    logic              acc;
    logic              capture;
    logic              cap_sel;
    logic [TAG_W-1:0]  cap_tag;
    logic [RD_W-1:0]   cap_rd;
    logic              unused_opcode_msb;

    assign unused_opcode_msb = in_opcode[2];

    assign in_ready = ~flush & ((state == IDLE) | ((state == DONE) & wb_ready));
    assign acc      = in_valid & in_ready;

    assign div_start    = acc;
    assign div_opcode   = acc ? (in_opcode[0] ? DIV_OP_DIVU : DIV_OP_DIV) : 3'b000;
    assign div_divident = acc ? in_src1 : '0;
    assign div_divisor  = acc ? in_src2 : '0;

    assign wb_valid = (state == DONE) & ~flush;
    assign busy     = (state != IDLE);

    // A divider that finishes in the start cycle has not seen the op fields registered yet.
    assign cap_sel = acc ? in_opcode[1] : sel_rem;
    assign cap_tag = acc ? in_tag : op_tag;
    assign cap_rd  = acc ? in_rd : op_rd;

    always_comb begin
        state_next = state;
        kill_next  = kill;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (acc) begin
                    state_next = div_finish ? DONE : RUN;
                    capture    = div_finish;
                end
            end
            RUN: begin
                if (div_finish) begin
                    if (kill | flush) begin
                        state_next = IDLE;
                        kill_next  = 1'b0;
                    end else begin
                        state_next = DONE;
                        capture    = 1'b1;
                    end
                end else if (flush) begin
                    kill_next = 1'b1;
                end
            end
            DONE: begin
                // acc here implies wb_ready, so the held result drains on this edge
                if (flush) begin
                    state_next = IDLE;
                end else if (acc) begin
                    state_next = div_finish ? DONE : RUN;
                    capture    = div_finish;
                end else if (wb_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            kill    <= 1'b0;
            sel_rem <= 1'b0;
            op_tag  <= '0;
            op_rd   <= '0;
            wb_data <= '0;
            wb_tag  <= '0;
            wb_rd   <= '0;
        end else begin
            state <= state_next;
            kill  <= kill_next;
            if (acc) begin
                sel_rem <= in_opcode[1];
                op_tag  <= in_tag;
                op_rd   <= in_rd;
            end
            if (capture) begin
                wb_data <= cap_sel ? div_remainder : div_quotient;
                wb_tag  <= cap_tag;
                wb_rd   <= cap_rd;
            end
        end
    end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - directed and randomized checks of div_issue_ctrl against a transaction-level model
module tb_div_issue_ctrl;
    localparam int W  = 32;
    localparam int TW = 6;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_opcode = 3'b100;
    logic [W-1:0]  in_src1 = '0;
    logic [W-1:0]  in_src2 = '0;
    logic [TW-1:0] in_tag = '0;
    logic [RW-1:0] in_rd = '0;
    logic          flush = 1'b0;
    logic          div_start;
    logic [2:0]    div_opcode;
    logic [W-1:0]  div_divident;
    logic [W-1:0]  div_divisor;
    logic [W-1:0]  div_quotient = '0;
    logic [W-1:0]  div_remainder = '0;
    logic          div_finish = 1'b0;
    logic          wb_valid;
    logic          wb_ready = 1'b1;
    logic [W-1:0]  wb_data;
    logic [TW-1:0] wb_tag;
    logic [RW-1:0] wb_rd;
    logic          busy;

    always #5 clk = ~clk;

    div_issue_ctrl #(.WORD_WIDTH(W), .TAG_W(TW), .RD_W(RW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag), .in_rd(in_rd),
        .flush(flush),
        .div_start(div_start), .div_opcode(div_opcode),
        .div_divident(div_divident), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder), .div_finish(div_finish),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_tag(wb_tag), .wb_rd(wb_rd), .busy(busy)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // bench-side divider
    bit          dv_busy = 0;
    int          dv_cnt = 0;
    logic [W-1:0] dv_q, dv_r;
    bit          orphan = 0;
    int          lat_force = 0;

    function automatic logic [63:0] ref_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q, r;
        int sa, sb;
        if (b == 0) return {32'hFFFF_FFFF, a};
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {a, 32'h0};
        if (sgn) begin
            sa = a; sb = b;
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    // transaction-level model: one op in the divider, one result on offer
    bit            m_inflight = 0, m_killed = 0, m_sel = 0, m_held = 0;
    logic [TW-1:0] m_itag = '0, m_tag = '0;
    logic [RW-1:0] m_ird = '0, m_rd = '0;
    logic [W-1:0]  m_data = '0;

    logic          s_ready, s_start, s_wbv, s_busy;
    logic [2:0]    s_opc;
    logic [W-1:0]  s_data;
    logic [TW-1:0] s_tag;
    logic [RW-1:0] s_rd;

    task automatic step();
        bit e_ready, e_acc, e_wbv, started, trivial;
        logic [63:0] qr;
        #1;
        started = 0;
        trivial = 0;
        div_finish = 1'b0;
        div_quotient = $urandom;
        div_remainder = $urandom;
        if (dv_busy) begin
            if (dv_cnt == 0) begin
                div_finish = 1'b1;
                div_quotient = dv_q;
                div_remainder = dv_r;
            end
        end else if (div_start) begin
            started = 1;
            qr = ref_div(~div_opcode[0], div_divident, div_divisor);
            dv_q = qr[63:32];
            dv_r = qr[31:0];
            if (div_divisor == 0 || (!div_opcode[0] && div_divident == 32'h8000_0000 &&
                                     div_divisor == 32'hFFFF_FFFF)) begin
                trivial = 1;
                div_finish = 1'b1;
                div_quotient = dv_q;
                div_remainder = dv_r;
            end
        end
        #1;
        e_ready = !flush && !m_inflight && (!m_held || wb_ready);
        e_acc   = in_valid && e_ready;
        e_wbv   = m_held && !flush;
        chk("in_ready", in_ready, e_ready);
        chk("div_start", div_start, e_acc);
        chk("div_opcode", div_opcode, e_acc ? (in_opcode[0] ? 3'b101 : 3'b100) : 3'b000);
        chk("div_divident", div_divident, e_acc ? in_src1 : 32'h0);
        chk("div_divisor", div_divisor, e_acc ? in_src2 : 32'h0);
        chk("wb_valid", wb_valid, e_wbv);
        chk("busy", busy, m_inflight || m_held);
        if (e_wbv) begin
            chk("wb_data", wb_data, m_data);
            chk("wb_tag", wb_tag, m_tag);
            chk("wb_rd", wb_rd, m_rd);
        end
        s_ready = in_ready; s_start = div_start; s_opc = div_opcode; s_wbv = wb_valid;
        s_busy = busy; s_data = wb_data; s_tag = wb_tag; s_rd = wb_rd;
        if (rst) begin
            m_inflight = 0; m_killed = 0; m_held = 0;
        end else begin
            if (m_held && (flush || wb_ready)) m_held = 0;
            if (e_acc) begin
                m_inflight = 1; m_killed = 0; m_sel = in_opcode[1];
                m_itag = in_tag; m_ird = in_rd;
            end
            if (m_inflight && div_finish) begin
                if (!m_killed && !flush) begin
                    m_held = 1;
                    m_data = m_sel ? div_remainder : div_quotient;
                    m_tag = m_itag;
                    m_rd = m_ird;
                end
                m_inflight = 0;
                m_killed = 0;
            end else if (m_inflight && flush) begin
                m_killed = 1;
            end
        end
        @(posedge clk);
        if (dv_busy) begin
            if (div_finish) begin
                dv_busy = 0;
                orphan = 0;
            end else dv_cnt--;
        end else if (started && !trivial) begin
            dv_busy = 1;
            dv_cnt = (lat_force > 0 ? lat_force : int'($urandom_range(1, 6))) - 1;
        end
        if (rst && dv_busy) orphan = 1;
        #1;
    endtask

    task automatic op(input logic [2:0] opc, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [TW-1:0] tag, input logic [RW-1:0] rd);
        in_valid = 1'b1; in_opcode = opc; in_src1 = a; in_src2 = b; in_tag = tag; in_rd = rd;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_div_start", div_start, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_tag", wb_tag, 0);
        chk("rst_wb_rd", wb_rd, 0);

        // DIVU 100/7
        lat_force = 3;
        op(3'b101, 100, 7, 6'd5, 5'd9);
        step();
        chk("t1_start", s_start, 1);
        chk("t1_opc", s_opc, 3'b101);
        in_valid = 1'b0;
        step();
        chk("t1_single_pulse", s_start, 0);
        step(); step();
        step();
        chk("t1_wbv", s_wbv, 1);
        chk("t1_data", s_data, 14);
        chk("t1_tag", s_tag, 5);
        chk("t1_rd", s_rd, 9);

        // REM -7 % 2
        lat_force = 2;
        op(3'b110, 32'hFFFF_FFF9, 2, 6'd7, 5'd3);
        step();
        chk("t2_opc", s_opc, 3'b100);
        in_valid = 1'b0;
        step(); step();
        step();
        chk("t2_wbv", s_wbv, 1);
        chk("t2_data", s_data, 32'hFFFF_FFFF);

        // divide by zero finishes in the start cycle
        op(3'b101, 5, 0, 6'd1, 5'd1);
        step();
        in_valid = 1'b0;
        step();
        chk("t3_divu_wbv", s_wbv, 1);
        chk("t3_divu_data", s_data, 32'hFFFF_FFFF);
        op(3'b111, 5, 0, 6'd2, 5'd2);
        step();
        in_valid = 1'b0;
        step();
        chk("t3_remu_wbv", s_wbv, 1);
        chk("t3_remu_data", s_data, 5);

        // flush two cycles after accept kills the op
        lat_force = 6;
        op(3'b100, 1000, 3, 6'd3, 5'd4);
        step();
        in_valid = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        lat_force = 1;
        op(3'b101, 9, 3, 6'd4, 5'd5);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_busy", s_busy, 1);
            chk("t4_ready", s_ready, 0);
            chk("t4_wbv", s_wbv, 0);
        end
        step();
        chk("t4_idle_busy", s_busy, 0);
        chk("t4_next_start", s_start, 1);
        in_valid = 1'b0;
        step();
        step();
        chk("t4_next_wbv", s_wbv, 1);
        chk("t4_next_data", s_data, 3);
        chk("t4_next_tag", s_tag, 4);

        // result held under backpressure, then same-cycle accept
        lat_force = 2;
        op(3'b101, 100, 7, 6'd8, 5'd8);
        step();
        in_valid = 1'b0;
        wb_ready = 1'b0;
        step(); step();
        op(3'b101, 9, 3, 6'd9, 5'd9);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_hold_wbv", s_wbv, 1);
            chk("t5_hold_data", s_data, 14);
            chk("t5_hold_ready", s_ready, 0);
            chk("t5_hold_nostart", s_start, 0);
        end
        wb_ready = 1'b1;
        step();
        chk("t5_drain_start", s_start, 1);
        chk("t5_drain_wbv", s_wbv, 1);
        in_valid = 1'b0;
        step(); step();
        step();
        chk("t5_new_data", s_data, 3);
        chk("t5_new_tag", s_tag, 9);

        // reset mid-RUN, then flush in DONE
        lat_force = 5;
        op(3'b100, 50, 5, 6'd10, 5'd10);
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("t6_rst_busy", s_busy, 0);
        chk("t6_rst_wbv", s_wbv, 0);
        chk("t6_rst_ready", s_ready, 1);
        chk("t6_rst_data", s_data, 0);
        repeat (6) step();
        wb_ready = 1'b0;
        op(3'b101, 5, 0, 6'd11, 5'd11);
        step();
        in_valid = 1'b0;
        flush = 1'b1;
        step();
        chk("t6_flush_wbv", s_wbv, 0);
        flush = 1'b0;
        step();
        chk("t6_flush_busy", s_busy, 0);
        chk("t6_flush_wbv2", s_wbv, 0);
        wb_ready = 1'b1;

        lat_force = 0;
        for (int i = 0; i < 4000; i++) begin
            int r;
            in_valid  = ($urandom % 10 < 6) && !orphan;
            in_opcode = 3'b100 | 3'($urandom % 4);
            in_src1   = ($urandom % 8 == 0) ? 32'h8000_0000 : $urandom;
            r = $urandom % 8;
            in_src2   = (r == 0) ? 32'h0 : (r == 1) ? 32'hFFFF_FFFF : $urandom_range(1, 1000);
            in_tag    = TW'($urandom);
            in_rd     = RW'($urandom);
            flush     = ($urandom % 10 == 0);
            wb_ready  = ($urandom % 10 < 6);
            rst       = ($urandom % 200 == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Front-end controller for the iterative divider in the execute stage. It accepts one divide/remainder micro-op at a time from the issue queue over a valid/ready handshake and launches the divider with a one-cycle `div_start` pulse. It waits for `div_finish`, then selects quotient or remainder and holds the result until the writeback arbiter accepts it. A pipeline `flush` kills the in-flight op; because the divider cannot be aborted, a killed op's result is silently discarded.

## Interface
- `TAG_W`, default 6: width of the ROB tag carried with each op.
- `RD_W`, default 5: width of the destination register index.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  issue queue presents an op.
- `in_ready`  out  1  controller accepts the op this cycle.
- `in_opcode`  in  3  `DIV_OP_DIV`, `DIV_OP_DIVU`, `DIV_OP_REM`, `DIV_OP_REMU` (3'b100, 3'b101, 3'b110, 3'b111).
- `in_src1`  in  `WORD_WIDTH`  dividend.
- `in_src2`  in  `WORD_WIDTH`  divisor.
- `in_tag`  in  `TAG_W`  ROB tag.
- `in_rd`  in  `RD_W`  destination register.
- `flush`  in  1  kill all uncommitted work.
- `div_start`  out  1  start pulse to the divider.
- `div_opcode`  out  3  signedness to the divider: `DIV_OP_DIV` or `DIV_OP_DIVU` only.
- `div_divident`  out  `WORD_WIDTH`  dividend to the divider.
- `div_divisor`  out  `WORD_WIDTH`  divisor to the divider.
- `div_quotient`  in  `WORD_WIDTH`  divider quotient; valid while `div_finish`=1.
- `div_remainder`  in  `WORD_WIDTH`  divider remainder; valid while `div_finish`=1.
- `div_finish`  in  1  divider result valid. It can be high in the same cycle as `div_start`, for divide-by-zero or overflow.
- `wb_valid`  out  1  result held for writeback.
- `wb_ready`  in  1  writeback arbiter takes the result.
- `wb_data`  out  `WORD_WIDTH`  selected result.
- `wb_tag`  out  `TAG_W`  tag of the result.
- `wb_rd`  out  `RD_W`  destination register of the result.
- `busy`  out  1  state ≠ IDLE.

## Operation
- States:
  - IDLE: no op held.
  - RUN: divider iterating.
  - DONE: result held in the output register.
- Accept condition: `acc = in_valid & in_ready`.
  - `in_ready = ~flush & (IDLE | (DONE & wb_ready))`.
- `div_start = acc`. This path is combinational; the divider latches its operands on the start cycle.
- On `acc`, drive the divider as follows:
  - `div_divident = in_src1`, `div_divisor = in_src2`.
  - `div_opcode`: DIV and REM → `DIV_OP_DIV`; DIVU and REMU → `DIV_OP_DIVU`.
  - When `acc`=0, drive all three outputs to 0.
- On `acc`, register the op's fields: `sel_rem = in_opcode[1]`, `in_tag`, `in_rd`.
- Result selection: `wb_data` is captured from `div_remainder` if `sel_rem`, else from `div_quotient`.
  - In the start cycle, use the incoming `in_opcode[1]` rather than the registered copy.
- Transitions:
  - IDLE, `acc`, `div_finish`=1 → DONE, result captured.
  - IDLE, `acc`, `div_finish`=0 → RUN.
  - RUN, `div_finish`, `kill`=0, `flush`=0 → DONE, result captured.
  - RUN, `div_finish`, and (`kill` or `flush`) → IDLE, nothing captured; clear `kill`.
  - RUN, `flush`, no `div_finish` → stay in RUN, set `kill`.
  - DONE, `flush` → IDLE, result dropped. `wb_valid` is forced low in that cycle.
  - DONE, `wb_ready`, no `acc` → IDLE.
  - DONE, `wb_ready`, `acc` → RUN or DONE by the IDLE rules above. The new result overwrites the output register only on the edge after the current result is consumed.
- `wb_valid = DONE & ~flush`.
- `wb_data`, `wb_tag`, `wb_rd` are stable while `wb_valid` & ~`wb_ready`.
- Reset: state = IDLE, `kill`=0, and all registered outputs = 0.
  - So `in_ready`=1 (if `flush`=0), `busy`=0, `wb_valid`=0, `div_start`=0.
- Reset mid-RUN: return to IDLE. Any later `div_finish` seen in IDLE is ignored.
- `div_finish` in IDLE without `acc` is ignored.
- `in_valid` together with `flush` is not accepted. The issue queue holds or drops the op.

## Timing
- Accept cycle T: `div_start`=1 at T.
- Trivial divide (`div_finish`=1 at T): `wb_valid`=1 at T+1.
- Iterative divide: the divider asserts `div_finish` at cycle F > T; `wb_valid`=1 at F+1.
- Throughput: one op per divide latency + 1 cycle.
  - A new op is accepted in the same cycle the previous result drains, so there is no idle bubble.
- `in_ready` depends combinationally on `wb_ready` and `flush` only. There is no path from `in_valid` to `in_ready`.
- `kill` survives any number of further `flush` pulses and clears only on `div_finish` or `rst`.

## Test plan
- DIVU, src1=100, src2=7, `wb_ready`=1 → `div_start` for 1 cycle, `div_opcode`=3'b101; `wb_valid` one cycle after `div_finish` with `wb_data`=14 and the correct tag/rd.
- REM, src1=0xFFFFFFF9 (−7), src2=2 → `div_opcode`=3'b100, `wb_data`=0xFFFFFFFF (−1).
- DIVU, src1=5, src2=0 → `div_finish` in the start cycle; `wb_valid` at T+1 with `wb_data`=0xFFFFFFFF. REMU with the same operands → `wb_data`=5.
- DIV, src1=1000, src2=3, with `flush` 2 cycles after accept → `in_ready`=0 and `busy`=1 until `div_finish`; no `wb_valid`; IDLE the cycle after finish; the next op then completes normally.
- Result 14 held with `wb_ready`=0 for 5 cycles → `wb_valid` and `wb_data`=14 stable, `in_ready`=0. Then `wb_ready`=1 with a pending DIVU 9/3 → same-cycle accept, followed later by `wb_data`=3.
- `rst` asserted mid-RUN and `flush` in DONE → outputs return to reset values; the dropped result never appears on `wb_valid`.
